// File: rtl/irq_pkg.sv
// Shared definitions for the 8-input interrupt controller.
//   OFS_*   : register offsets relative to BASE_PORT
//   EOI_BIT : command-register bit that issues a non-specific EOI
//   state_t : delivery FSM states
package irq_pkg;

  localparam logic [15:0] OFS_CMD = 16'd0;
  localparam logic [15:0] OFS_IMR = 16'd1;
  localparam logic [15:0] OFS_VB  = 16'd2;

  localparam int unsigned EOI_BIT = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/irq_prio.sv
// 8-bit fixed-priority encoder, index 0 highest.
//   req   : request vector
//   idx   : index of the lowest set bit (0 when none)
//   valid : at least one bit of req is set
module irq_prio (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (req[i] && !valid) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Programmable 8-input edge-triggered interrupt controller with fixed
// priority (line 0 highest) and a toggle handshake towards the core.
//   clock, reset_n : clock, synchronous active-low reset
//   irq_line       : asynchronous request lines, rising edge requests
//   port_a/wr/wd   : I/O write bus from the core (BASE_PORT+0..+2)
//   port_rd        : combinational read data for port_a
//   irq, intr      : posted vector and request toggle to the core
//   intl           : acknowledge toggle from the core
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE_PORT   = 16'h0020,
  parameter logic [7:0]  VEC_RESET   = 8'h08,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  irq_line,
  input  logic [15:0] port_a,
  input  logic        port_wr,
  input  logic [7:0]  port_wd,
  output logic [7:0]  port_rd,
  output logic [7:0]  irq,
  output logic        intr,
  input  logic        intl
);

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] vb_q, vb_d;
  logic [7:0] irq_q, irq_d;
  logic       intr_q, intr_d;
  logic [2:0] cur_q, cur_d;
  state_t     state_q, state_d;

  logic       sel_cmd, sel_imr, sel_vb;
  logic [7:0] sync_out, rise, eligible;
  logic [7:0] irr_clr, isr_set, isr_eoi;
  logic [2:0] req_idx, isr_idx;
  logic       req_valid, isr_valid, cand_ok;

  assign sel_cmd = (port_a == BASE_PORT + OFS_CMD);
  assign sel_imr = (port_a == BASE_PORT + OFS_IMR);
  assign sel_vb  = (port_a == BASE_PORT + OFS_VB);

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~edge_q;
  assign eligible = irr_q & ~imr_q;

  irq_prio u_prio_req (
    .req   (eligible),
    .idx   (req_idx),
    .valid (req_valid)
  );

  irq_prio u_prio_isr (
    .req   (isr_q),
    .idx   (isr_idx),
    .valid (isr_valid)
  );

  // A candidate is blocked by any in-service line of equal or higher priority.
  assign cand_ok = req_valid && (!isr_valid || (isr_idx > req_idx));

  always_comb begin
    sync_d[0] = irq_line;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    edge_d = sync_out;
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    intr_d  = intr_q;
    cur_d   = cur_q;
    imr_d   = imr_q;
    vb_d    = vb_q;
    irr_clr = '0;
    isr_set = '0;
    isr_eoi = '0;

    case (state_q)
      IDLE: begin
        if (cand_ok) begin
          irq_d   = vb_q | {5'b00000, req_idx};
          intr_d  = ~intr_q;
          cur_d   = req_idx;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (intl == intr_q) begin
          irr_clr[cur_q] = 1'b1;
          isr_set[cur_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI acts on the pre-cycle ISR; a same-cycle acceptance is OR-ed in after.
    if (port_wr && sel_cmd && port_wd[EOI_BIT] && isr_valid) begin
      isr_eoi[isr_idx] = 1'b1;
    end
    if (port_wr && sel_imr) begin
      imr_d = port_wd;
    end
    if (port_wr && sel_vb) begin
      vb_d = {port_wd[7:3], 3'b000};
    end

    // A new edge wins over a same-cycle acceptance clear.
    irr_d = (irr_q & ~irr_clr) | rise;
    isr_d = (isr_q & ~isr_eoi) | isr_set;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q  <= '0;
      edge_q  <= '0;
      irr_q   <= '0;
      isr_q   <= '0;
      imr_q   <= '1;
      vb_q    <= VEC_RESET;
      irq_q   <= VEC_RESET;
      intr_q  <= intl;
      cur_q   <= '0;
      state_q <= IDLE;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;
      vb_q    <= vb_d;
      irq_q   <= irq_d;
      intr_q  <= intr_d;
      cur_q   <= cur_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    port_rd = '0;
    if (sel_cmd) begin
      port_rd = irr_q;
    end else if (sel_imr) begin
      port_rd = imr_q;
    end else if (sel_vb) begin
      port_rd = isr_q;
    end
  end

  assign irq  = irq_q;
  assign intr = intr_q;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  localparam logic [15:0] BASE = 16'h0020;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  irq_line = '0;
  logic [15:0] port_a = '0;
  logic        port_wr = 1'b0;
  logic [7:0]  port_wd = '0;
  logic [7:0]  port_rd;
  logic [7:0]  irq;
  logic        intr;
  logic        intl = 1'b0;

  irq_controller #(
    .BASE_PORT   (BASE),
    .VEC_RESET   (8'h08),
    .SYNC_STAGES (2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .irq_line (irq_line),
    .port_a   (port_a),
    .port_wr  (port_wr),
    .port_wd  (port_wd),
    .port_rd  (port_rd),
    .irq      (irq),
    .intr     (intr),
    .intl     (intl)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and expected posted vectors.
  logic [7:0] m_irr, m_isr, m_imr, m_vb;
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp;
  bit         have_cur = 1'b0;
  bit         ack_en = 1'b0;
  int         ack_wait = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 8;
  endfunction

  // Deliver every vector the rules allow with an always-acknowledging core.
  task automatic model_deliver();
    for (int k = 0; k < 8; k++) begin
      int n;
      n = lowest(m_irr & ~m_imr);
      if (n >= 8 || lowest(m_isr) <= n) break;
      exp_q.push_back(m_vb | 8'(n));
      m_irr[n] = 1'b0;
      m_isr[n] = 1'b1;
    end
  endtask

  // Monitor: every new request toggle presents a vector to be checked.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev     = intr;
        have_cur = 1'b0;
      end else if (intr !== prev) begin
        prev = intr;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_post: irq %02h posted, no vector expected", irq);
        end else begin
          cur_exp  = exp_q.pop_front();
          have_cur = 1'b1;
          check8("post_vector", irq, cur_exp);
        end
      end else if (have_cur && intr !== intl) begin
        check8("hold_vector", irq, cur_exp);
      end
    end
  end

  // One cycle, with the core acknowledging after a random delay.
  task automatic tick();
    @(negedge clock);
    if (ack_en && intr !== intl) begin
      if (ack_wait == 0) begin
        intl     = intr;
        ack_wait = $urandom_range(0, 2);
      end else begin
        ack_wait--;
      end
    end
  endtask

  task automatic wr(input logic [15:0] ofs, input logic [7:0] d);
    port_a  = BASE + ofs;
    port_wd = d;
    port_wr = 1'b1;
    tick();
    port_wr = 1'b0;
    port_a  = '0;
  endtask

  task automatic chk_reg(input string name, input logic [15:0] ofs, input logic [7:0] exp);
    port_a = BASE + ofs;
    #1;
    check8(name, port_rd, exp);
    port_a = '0;
  endtask

  task automatic check_regs();
    chk_reg("irr", 16'd0, m_irr);
    chk_reg("imr", 16'd1, m_imr);
    chk_reg("isr", 16'd2, m_isr);
  endtask

  task automatic settle();
    repeat (60) tick();
    check8("pending_vectors", 8'(exp_q.size()), 8'd0);
    if (ack_en) check8("handshake_idle", {7'b0, intr}, {7'b0, intl});
  endtask

  task automatic op_pulse(input logic [7:0] p);
    m_irr = m_irr | p;
    model_deliver();
    irq_line = p;
    repeat (3) tick();
    irq_line = '0;
    repeat (3) tick();
    settle();
  endtask

  task automatic op_imr(input logic [7:0] v);
    m_imr = v;
    model_deliver();
    wr(16'd1, v);
    settle();
  endtask

  task automatic op_eoi();
    if (m_isr != 0) m_isr[lowest(m_isr)] = 1'b0;
    model_deliver();
    wr(16'd0, 8'($urandom) | 8'h20);
    settle();
  endtask

  task automatic op_vb(input logic [7:0] v);
    m_vb = v & 8'hF8;
    wr(16'd2, v);
  endtask

  task automatic wait_post(input string name);
    int n;
    n = 0;
    while (intr === intl && n < 20) begin
      tick();
      n++;
    end
    if (intr === intl) begin
      checks++;
      errors++;
      $display("FAIL %s: no request toggle within 20 cycles", name);
    end
  endtask

  task automatic do_reset(input logic intl_val);
    ack_en   = 1'b0;
    reset_n  = 1'b0;
    intl     = intl_val;
    irq_line = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    m_irr = '0; m_isr = '0; m_imr = 8'hFF; m_vb = 8'h08;
    exp_q.delete();
    tick();
    check8("intr_resync", {7'b0, intr}, {7'b0, intl_val});
    check8("irq_reset", irq, 8'h08);
    check_regs();
  endtask

  initial begin
    logic i0;
    m_irr = '0; m_isr = '0; m_imr = 8'hFF; m_vb = 8'h08;

    // Reset values and basic delivery latency.
    do_reset(1'b0);
    m_imr = 8'hFE;
    wr(16'd1, 8'hFE);
    op_vb(8'h08);
    m_irr = 8'h01;
    model_deliver();
    i0 = intr;
    irq_line[0] = 1'b1;
    repeat (3) tick();
    chk_reg("irr_latency", 16'd0, 8'h01);
    check8("intr_early", {7'b0, intr}, {7'b0, i0});
    tick();
    check8("intr_latency", {7'b0, intr}, {7'b0, ~i0});
    check8("vector_line0", irq, 8'h08);
    irq_line = '0;
    ack_en = 1'b1;
    settle();
    check_regs();
    op_eoi();

    // Priority, blocking by in-service lines, nesting, masking.
    op_imr(8'h00);
    op_pulse(8'h0A);
    check_regs();
    op_eoi();
    check_regs();
    op_eoi();
    op_pulse(8'h20);
    op_pulse(8'h04);
    op_pulse(8'h40);
    check_regs();
    op_eoi();
    check_regs();
    op_eoi();
    op_eoi();
    check_regs();
    op_imr(8'hFF);
    op_pulse(8'h10);
    check_regs();
    op_imr(8'hEF);
    check_regs();
    op_eoi();

    // Reset with intl high: intr resyncs, nothing posted.
    do_reset(1'b1);
    ack_en = 1'b1;
    settle();

    // Reset while a request is waiting for acknowledge.
    do_reset(1'b0);
    m_imr = 8'h00;
    wr(16'd1, 8'h00);
    m_irr = 8'h08;
    model_deliver();
    irq_line[3] = 1'b1;
    wait_post("post_line3");
    repeat (3) tick();
    check8("wait_vector", irq, 8'h0B);
    do_reset(1'b0);

    // New edge on line 2 in the very cycle its request is accepted.
    m_imr = 8'h00;
    wr(16'd1, 8'h00);
    m_irr = 8'h04;
    model_deliver();
    irq_line[2] = 1'b1;
    wait_post("post_line2");
    irq_line = '0;
    repeat (3) tick();
    irq_line[2] = 1'b1;
    repeat (2) tick();
    intl = intr;
    tick();
    irq_line = '0;
    m_irr = 8'h04;
    check_regs();
    ack_en = 1'b1;
    op_eoi();
    check_regs();
    op_eoi();

    // Randomized operations against the model.
    for (int t = 0; t < 150; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        op_pulse(8'($urandom));
      end else if (r < 65) begin
        op_eoi();
      end else if (r < 80) begin
        op_imr(8'($urandom) & 8'($urandom));
      end else if (r < 90) begin
        op_vb(8'($urandom));
      end else if (r < 95) begin
        wr(16'd0, 8'($urandom) & 8'hDF);
        settle();
      end else begin
        logic [15:0] ofs;
        ofs = 16'(3 + $urandom_range(0, 100));
        wr(ofs, 8'($urandom));
        chk_reg("unmapped_read", ofs, 8'h00);
        settle();
      end
      check_regs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
